fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_push_arbiter_if.sv | 37 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fifo_push_arbiter.sv | 87 ++++++++
 tb/tb_fifo_push_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
// State encoding, counter width and pointer wrap.
package fifo_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int CNT_W = 16;

  // Modulo wrap so non-power-of-two requester counts stay in range
  function automatic int rr_wrap(input int v, input int n);
    return v % n;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester, consumer and FIFO-side signals of the push arbiter.
// slave is the arbiter side, master the surrounding system.
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MULTI_POP  = 1
);
  localparam int CW = $clog2(MULTI_POP) + 1;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [CW-1:0]                      cons_poll_cnt;
  logic                               flush;
  logic                               flush_busy;
  logic                               fifo_push;
  logic [DATA_WIDTH-1:0]              fifo_data;
  logic [CW-1:0]                      fifo_poll_cnt;
  logic [CW-1:0]                      fifo_ready_cnt;
  logic                               fifo_full;
  logic [15:0]                        accept_cnt;

  modport slave (
    input  req_valid, req_data, cons_poll_cnt, flush,
    input  fifo_ready_cnt, fifo_full,
    output req_ready, flush_busy, fifo_push, fifo_data,
    output fifo_poll_cnt, accept_cnt
  );

  modport master (
    output req_valid, req_data, cons_poll_cnt, flush,
    output fifo_ready_cnt, fifo_full,
    input  req_ready, flush_busy, fifo_push, fifo_data,
    input  fifo_poll_cnt, accept_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans from ptr_i upward with wrap; first valid request wins.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  logic          found;
  logic [PW-1:0] k;

  // Priority scan starting at the pointer
  always_comb begin
    found = 1'b0;
    k     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = PW'(rr_wrap(int'(ptr_i) + i, NUM_REQ));
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Arbitrates requester pushes into one shared FIFO.
// RUN grants round-robin; DRAIN pops at full width until empty.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MULTI_POP  = 1
) (
  input logic               clk,
  input logic               rst_n,
  fifo_push_arbiter_if.slave bus
);

  localparam int CW = $clog2(MULTI_POP) + 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   ready;
  logic [PW-1:0]        gnt_idx;
  logic                 grant_en;
  logic                 push;
  logic [DATA_WIDTH-1:0] data_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Grant gating and output muxing; everything forced low in reset
  always_comb begin
    grant_en = rst_n && (state_q == RUN)
             && !bus.flush && !bus.fifo_full;
    ready    = grant_en ? gnt : '0;
    push     = |(bus.req_valid & ready);
    data_sel = push ? bus.req_data[gnt_idx] : '0;
    bus.req_ready  = ready;
    bus.fifo_push  = push;
    bus.fifo_data  = data_sel;
    bus.flush_busy = rst_n && (state_q == DRAIN);
    bus.accept_cnt = cnt_q;
    if (!rst_n)
      bus.fifo_poll_cnt = '0;
    else if (state_q == DRAIN)
      bus.fifo_poll_cnt = CW'(MULTI_POP);
    else
      bus.fifo_poll_cnt = bus.cons_poll_cnt;
  end

  // Next state, pointer advance and saturating accept count
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN:   if (bus.flush) state_d = DRAIN;
      DRAIN: if (bus.fifo_ready_cnt == CW'(0)) state_d = RUN;
    endcase
    if (push) begin
      ptr_d = PW'(rr_wrap(int'(gnt_idx) + 1, NUM_REQ));
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, pointer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MP = 2;
  localparam int CW = 2;
  localparam int VW = N + 1 + DW + CW + 1 + 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_push_arbiter_if #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MULTI_POP  (MP)
  ) bus ();

  fifo_push_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MULTI_POP  (MP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit m_run;
  int m_ptr;
  int m_cnt;

  int            e_idx;
  logic [N-1:0]  e_ready;
  logic          e_push;
  logic [DW-1:0] e_data;
  logic [CW-1:0] e_poll;
  logic          e_busy;

  logic [DW-1:0] fq[$];

  task automatic model_reset();
    m_run = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // Expected outputs: nearest valid requester at or after the pointer
  task automatic model_eval();
    int k;
    e_idx = -1;
    if (m_run && !bus.flush && !bus.fifo_full)
      for (int d = 0; d < N; d++) begin
        k = (m_ptr + d) % N;
        if (e_idx < 0 && bus.req_valid[k]) e_idx = k;
      end
    e_ready = '0;
    e_push  = 1'b0;
    e_data  = '0;
    if (e_idx >= 0) begin
      e_ready[e_idx] = 1'b1;
      e_push = 1'b1;
      e_data = bus.req_data[e_idx];
    end
    e_poll = m_run ? bus.cons_poll_cnt : CW'(MP);
    e_busy = !m_run;
  endtask

  task automatic model_clock();
    if (e_idx >= 0) begin
      m_ptr = (e_idx + 1) % N;
      if (m_cnt < 65535) m_cnt++;
    end
    if (m_run) begin
      if (bus.flush) m_run = 1'b0;
    end else if (bus.fifo_ready_cnt == 0) begin
      m_run = 1'b1;
    end
  endtask

  function automatic logic [VW-1:0] obs();
    return {bus.req_ready, bus.fifo_push, bus.fifo_data,
            bus.fifo_poll_cnt, bus.flush_busy, bus.accept_cnt};
  endfunction

  function automatic logic [VW-1:0] exp_v();
    return {e_ready, e_push, e_data, e_poll, e_busy, 16'(m_cnt)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic fl,
                        input logic fu, input logic [CW-1:0] rc,
                        input logic [CW-1:0] cp);
    bus.req_valid      = v;
    bus.flush          = fl;
    bus.fifo_full      = fu;
    bus.fifo_ready_cnt = rc;
    bus.cons_poll_cnt  = cp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data[i] = DW'(8'hA0 + i);
    set_in(4'b1111, 1'b0, 1'b0, 2'd0, 2'd3);
    #2;
    n_vec++;
    if (obs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want 0", obs());
    end
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fairness();
    set_in(4'b1111, 1'b0, 1'b0, 2'd0, 2'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      model_eval();
      n_vec++;
      if (obs() !== exp_v()) begin
        n_bad++;
        $display("FAIL fair_c%0d: got %h want %h", c, obs(), exp_v());
      end
      n_vec++;
      if (bus.req_ready !== 4'(1 << (c % 4))) begin
        n_bad++;
        $display("FAIL fair_order%0d: got %b want %b",
                 c, bus.req_ready, 4'(1 << (c % 4)));
      end
      model_clock();
      tick();
    end
    n_vec++;
    if (bus.accept_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL fair_cnt: got %0d want 5", bus.accept_cnt);
    end
  endtask

  task automatic test_skip_wrap();
    logic [N-1:0] vs [3];
    logic [N-1:0] gs [3];
    vs[0] = 4'b0010; gs[0] = 4'b0010;
    vs[1] = 4'b0011; gs[1] = 4'b0001;
    vs[2] = 4'b0010; gs[2] = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      set_in(vs[c], 1'b0, 1'b0, 2'd0, 2'd0);
      #1;
      model_eval();
      n_vec++;
      if (obs() !== exp_v() || bus.req_ready !== gs[c]) begin
        n_bad++;
        $display("FAIL skip_c%0d: got %h/%b want %h/%b",
                 c, obs(), bus.req_ready, exp_v(), gs[c]);
      end
      model_clock();
      tick();
    end
  endtask

  task automatic test_full_holdoff();
    for (int c = 0; c < 4; c++) begin
      set_in(4'b1111, 1'b0, c < 3, 2'd0, 2'd2);
      #1;
      model_eval();
      n_vec++;
      if (obs() !== exp_v()) begin
        n_bad++;
        $display("FAIL full_c%0d: got %h want %h", c, obs(), exp_v());
      end
      if (c < 3) begin
        n_vec++;
        if (bus.req_ready !== '0 || bus.fifo_push !== 1'b0) begin
          n_bad++;
          $display("FAIL full_hold%0d: got %b/%b want 0/0",
                   c, bus.req_ready, bus.fifo_push);
        end
      end else begin
        n_vec++;
        if (bus.req_ready !== 4'b0100) begin
          n_bad++;
          $display("FAIL full_resume: got %b want 0100",
                   bus.req_ready);
        end
      end
      model_clock();
      tick();
    end
  endtask

  task automatic test_drain();
    logic [CW-1:0] rc [6];
    logic          fl [6];
    int busy_cycles = 0;
    rc[0] = 2; rc[1] = 2; rc[2] = 2; rc[3] = 1; rc[4] = 0; rc[5] = 0;
    fl[0] = 1; fl[1] = 0; fl[2] = 1; fl[3] = 0; fl[4] = 0; fl[5] = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(4'b1111, fl[c], 1'b0, rc[c], 2'd1);
      #1;
      model_eval();
      if (bus.flush_busy === 1'b1) busy_cycles++;
      n_vec++;
      if (obs() !== exp_v()) begin
        n_bad++;
        $display("FAIL drain_c%0d: got %h want %h", c, obs(), exp_v());
      end
      if (c >= 1 && c <= 4) begin
        n_vec++;
        if (bus.fifo_poll_cnt !== 2'd2 || bus.req_ready !== '0) begin
          n_bad++;
          $display("FAIL drain_pop%0d: got %0d/%b want 2/0000",
                   c, bus.fifo_poll_cnt, bus.req_ready);
        end
      end
      model_clock();
      tick();
    end
    n_vec++;
    if (busy_cycles != 4) begin
      n_bad++;
      $display("FAIL drain_len: got %0d want 4", busy_cycles);
    end
  endtask

  task automatic test_flush_req();
    for (int c = 0; c < 3; c++) begin
      set_in(4'b0010, c == 0, 1'b0, 2'd0, 2'd1);
      #1;
      model_eval();
      n_vec++;
      if (obs() !== exp_v()) begin
        n_bad++;
        $display("FAIL flreq_c%0d: got %h want %h", c, obs(), exp_v());
      end
      n_vec++;
      if (bus.fifo_push !== (c == 2)) begin
        n_bad++;
        $display("FAIL flreq_push%0d: got %b want %b",
                 c, bus.fifo_push, c == 2);
      end
      model_clock();
      tick();
    end
  endtask

  task automatic test_mid_drain_reset();
    set_in(4'b1111, 1'b1, 1'b0, 2'd2, 2'd1);
    #1;
    model_eval();
    model_clock();
    tick();
    bus.flush = 1'b0;
    #1;
    model_eval();
    n_vec++;
    if (obs() !== exp_v() || bus.flush_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mrst_in_drain: got %h want %h", obs(), exp_v());
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs() !== '0) begin
      n_bad++;
      $display("FAIL mrst_outs: got %h want 0", obs());
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    #1;
    model_eval();
    n_vec++;
    if (obs() !== exp_v() || bus.req_ready !== 4'b0001
        || bus.accept_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mrst_after: got %h want %h", obs(), exp_v());
    end
    model_clock();
    tick();
  endtask

  task automatic test_random();
    int np;
    logic [N-1:0] v;
    v = bus.req_valid;
    fq.delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(1, 0) == 1) begin
          v[i] = 1'b1;
          bus.req_data[i] = DW'($urandom);
        end
      set_in(v, $urandom_range(15, 0) == 0, fq.size() >= 6,
             CW'((fq.size() < MP) ? fq.size() : MP),
             CW'($urandom_range(MP, 0)));
      #1;
      model_eval();
      n_vec++;
      if (obs() !== exp_v()) begin
        n_bad++;
        $display("FAIL rand_c%0d: got %h want %h", c, obs(), exp_v());
      end
      model_clock();
      np = (int'(e_poll) < fq.size()) ? int'(e_poll) : fq.size();
      for (int p = 0; p < np; p++) void'(fq.pop_front());
      if (e_push) fq.push_back(e_data);
      if (e_idx >= 0) v[e_idx] = 1'b0;
      tick();
    end
  endtask

  task automatic test_saturate();
    set_in(4'b1111, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int c = 0; c < 65600; c++) begin
      #1;
      model_eval();
      model_clock();
      tick();
    end
    #1;
    model_eval();
    n_vec++;
    if (obs() !== exp_v() || bus.accept_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_cnt: got %h want %h", obs(), exp_v());
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_skip_wrap();
    test_full_holdoff();
    test_drain();
    test_flush_req();
    test_mid_drain_reset();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
